// File: rtl/sobel_window_engine.sv
// rtl/sobel_window_engine.sv - pipelined 3x3 Sobel edge stage fed by the three-line window buffer
//
// Purpose: each accepted cycle takes three rows of two 32-bit window words and
// produces four saturated edge magnitudes plus a thresholded edge mask, three
// cycles later. Results are suppressed until PRIME_COUNT words of the current
// frame have been seen, so only windows built on valid line history leave the stage.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     window words valid this cycle
//   frame_start  first word of a new frame; restarts priming
//   w0..w5       window words: top {w0 left, w1 right}, middle {w2, w3}, bottom {w4, w5}
//   out_valid    one-cycle pulse, result valid
//   out_mag      four saturated magnitudes, byte k in bits [8k+7:8k]
//   out_edge     bit k set when the unsaturated magnitude of byte k >= THRESHOLD
module sobel_window_engine #(
  parameter logic [10:0] THRESHOLD   = 11'd128,
  parameter int unsigned PRIME_COUNT = 168
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        frame_start,
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [31:0] w2,
  input  logic [31:0] w3,
  input  logic [31:0] w4,
  input  logic [31:0] w5,
  output logic        out_valid,
  output logic [31:0] out_mag,
  output logic [3:0]  out_edge
);

  localparam logic [8:0] PRIME_MAX = 9'(PRIME_COUNT);

  // Weighted column difference: (a + 2b + c) - (d + 2e + f). Each sum is at
  // most 1020, so the 11-bit signed result never wraps.
  function automatic logic signed [10:0] diff3(input logic [7:0] pa, input logic [7:0] pb,
                                               input logic [7:0] pc, input logic [7:0] na,
                                               input logic [7:0] nb, input logic [7:0] nc);
    logic [9:0] w_pos;
    logic [9:0] w_neg;
    w_pos = 10'(pa) + {1'b0, pb, 1'b0} + 10'(pc);
    w_neg = 10'(na) + {1'b0, nb, 1'b0} + 10'(nc);
    return $signed({1'b0, w_pos}) - $signed({1'b0, w_neg});
  endfunction

  // |v| <= 1020 always fits in 10 bits.
  function automatic logic [9:0] abs11(input logic signed [10:0] v);
    logic signed [10:0] w_n;
    w_n = v[10] ? -v : v;
    return w_n[9:0];
  endfunction

  function automatic logic [7:0] px(input logic [63:0] row, input int idx);
    return row[8*idx +: 8];
  endfunction

  // Prime counter: an input is primed only if the counter already sat at
  // PRIME_MAX when it arrived; a frame_start word always starts a new count.
  logic [8:0] r_prime_cnt;
  logic       w_primed;

  assign w_primed = in_valid && !frame_start && (r_prime_cnt == PRIME_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prime_cnt <= 9'd0;
    end else if (frame_start) begin
      r_prime_cnt <= in_valid ? 9'd1 : 9'd0;
    end else if (in_valid && (r_prime_cnt != PRIME_MAX)) begin
      r_prime_cnt <= r_prime_cnt + 9'd1;
    end
  end

  // S1: capture the window rows as 64-bit pixel strips {right, left}. Only
  // primed words are carried, so unprimed data never disturbs held outputs.
  logic        r_s1_valid;
  logic [63:0] r_top;
  logic [63:0] r_mid;
  logic [63:0] r_bot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_top      <= '0;
      r_mid      <= '0;
      r_bot      <= '0;
    end else begin
      r_s1_valid <= w_primed;
      if (w_primed) begin
        r_top <= {w1, w0};
        r_mid <= {w3, w2};
        r_bot <= {w5, w4};
      end
    end
  end

  // S2: output k is centred on pixel column k+2 and uses columns k+1..k+3.
  logic signed [10:0] w_gx [4];
  logic signed [10:0] w_gy [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_gx[k] = diff3(px(r_top, k+3), px(r_mid, k+3), px(r_bot, k+3),
                      px(r_top, k+1), px(r_mid, k+1), px(r_bot, k+1));
      w_gy[k] = diff3(px(r_bot, k+1), px(r_bot, k+2), px(r_bot, k+3),
                      px(r_top, k+1), px(r_top, k+2), px(r_top, k+3));
    end
  end

  logic               r_s2_valid;
  logic signed [10:0] r_gx [4];
  logic signed [10:0] r_gy [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_gx[k] <= '0;
        r_gy[k] <= '0;
      end
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        for (int k = 0; k < 4; k++) begin
          r_gx[k] <= w_gx[k];
          r_gy[k] <= w_gy[k];
        end
      end
    end
  end

  // S3: the threshold sees the full 11-bit magnitude; only the byte saturates.
  logic [31:0] w_mag_sat;
  logic [3:0]  w_edge;
  logic [10:0] w_mag [4];

  always_comb begin
    w_mag_sat = '0;
    w_edge    = '0;
    for (int k = 0; k < 4; k++) begin
      w_mag[k]            = {1'b0, abs11(r_gx[k])} + {1'b0, abs11(r_gy[k])};
      w_mag_sat[8*k +: 8] = (w_mag[k] > 11'd255) ? 8'hFF : w_mag[k][7:0];
      w_edge[k]           = (w_mag[k] >= THRESHOLD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mag   <= 32'h0;
      out_edge  <= 4'h0;
    end else begin
      out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        out_mag  <= w_mag_sat;
        out_edge <= w_edge;
      end
    end
  end

endmodule
